// File: rtl/vga_frame_reader.sv
// VGA scan-out timing generator that pulls RGB565 pixels from a read FIFO and
// drives 8-bit RGB with active-low syncs through a fixed 2-clock video pipeline.
module vga_frame_reader #(
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LOAD_LEN = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [15:0] RD_DATA,
  output logic        RD_REQ,
  output logic        RD_LOAD,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [15:0] FRAME_CNT
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_LAST = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_LAST = VW'(V_ACT + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [15:0]   frame_cnt;
  logic          run, vid, active, hs_zone, vs_zone, load_win;
  logic [31:0]   load_pos;

  logic          vld_p1, hs_p1, vs_p1;
  logic          vld_p2, hs_p2, vs_p2;
  logic [7:0]    r_p2, g_p2, b_p2;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN)  state_nxt = RUN;
      RUN:     if (!EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Entering RUN starts in the vertical front porch so the reload strobe
  // precedes the first active line.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state == IDLE) begin
      if (EN) begin
        hcnt <= '0;
        vcnt <= V_ACT_C;
      end
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      frame_cnt <= '0;
    else if (run && hcnt == H_LAST && vcnt == V_LAST)
      frame_cnt <= frame_cnt + 16'd1;
  end

  always_comb begin
    run      = (state == RUN);
    vid      = run && EN;
    active   = run && (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    hs_zone  = (hcnt >= HS_BEG) && (hcnt <= HS_LAST);
    vs_zone  = (vcnt >= VS_BEG) && (vcnt <= VS_LAST);
    load_pos = 32'(vcnt - VS_BEG) * 32'(H_TOT) + 32'(hcnt);
    load_win = (vcnt >= VS_BEG) && (load_pos < 32'(LOAD_LEN));
  end

  assign RD_REQ    = active;
  assign RD_LOAD   = !run || load_win;
  assign FRAME_CNT = frame_cnt;

  // Stage 1: timing flags; the cycle that leaves RUN is already treated as blank.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      vld_p1 <= vid && active;
      hs_p1  <= !(vid && hs_zone);
      vs_p1  <= !(vid && vs_zone);
    end
  end

  // Stage 2: FIFO word arrives one clock after the request, aligned with stage-1 flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      r_p2   <= vld_p1 ? expand5(RD_DATA[15:11]) : 8'd0;
      g_p2   <= vld_p1 ? expand6(RD_DATA[10:5])  : 8'd0;
      b_p2   <= vld_p1 ? expand5(RD_DATA[4:0])   : 8'd0;
    end
  end

  assign VGA_R       = r_p2;
  assign VGA_G       = g_p2;
  assign VGA_B       = b_p2;
  assign VGA_HS      = hs_p2;
  assign VGA_VS      = vs_p2;
  assign VGA_BLANK_N = vld_p2;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader using a reduced 15x9 raster (135 clocks per frame).
module tb_vga_frame_reader;
  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int LOAD_LEN = 4;
  localparam int N = 136;

  logic        CLK = 1'b0;
  logic        RESET, EN;
  logic [15:0] RD_DATA;
  logic        RD_REQ, RD_LOAD;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [15:0] FRAME_CNT;

  int total = 0;
  int bad   = 0;

  logic        req_a [N];
  logic        load_a[N];
  logic        hs_a  [N];
  logic        vs_a  [N];
  logic        bn_a  [N];
  logic [23:0] rgb_a [N];
  logic [15:0] fc_a  [N];
  logic [15:0] pal   [3];

  vga_frame_reader #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .LOAD_LEN(LOAD_LEN)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .RD_DATA(RD_DATA),
    .RD_REQ(RD_REQ), .RD_LOAD(RD_LOAD),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int idle_err, n, cnt_req, cnt_load, cnt_hs, cnt_vs, cnt_bn, cnt_both;
    int first_load, first_req, load0;

    pal[0] = 16'hF800;
    pal[1] = 16'h07E0;
    pal[2] = 16'h001F;

    RESET = 1'b1; EN = 1'b0; RD_DATA = 16'hFFFF;
    repeat (2) step();
    chk("rst_load", 32'(RD_LOAD), 1);
    chk("rst_req", 32'(RD_REQ), 0);
    chk("rst_hs_vs", 32'({VGA_HS, VGA_VS}), 3);
    chk("rst_blank", 32'(VGA_BLANK_N), 0);
    chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
    chk("rst_fcnt", 32'(FRAME_CNT), 0);

    RESET = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (RD_LOAD !== 1'b1 || RD_REQ !== 1'b0 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1 ||
          VGA_BLANK_N !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 24'd0)
        idle_err++;
    end
    chk("idle_outputs", 32'(idle_err), 0);

    // One full frame from RUN entry; k=0 is the first RUN cycle at (h=0, v=V_ACT).
    EN = 1'b1;
    n = 0;
    for (int k = 0; k < N; k++) begin
      step();
      req_a[k]  = RD_REQ;
      load_a[k] = RD_LOAD;
      hs_a[k]   = VGA_HS;
      vs_a[k]   = VGA_VS;
      bn_a[k]   = VGA_BLANK_N;
      rgb_a[k]  = {VGA_R, VGA_G, VGA_B};
      fc_a[k]   = FRAME_CNT;
      if (k > 0 && req_a[k-1]) begin
        RD_DATA = pal[n % 3];
        n++;
      end else begin
        RD_DATA = 16'hFFFF;
      end
    end

    cnt_req = 0; cnt_load = 0; cnt_hs = 0; cnt_vs = 0; cnt_bn = 0; cnt_both = 0;
    first_load = -1; first_req = -1;
    for (int k = 0; k < N; k++) begin
      if (req_a[k]) cnt_req++;
      if (load_a[k]) cnt_load++;
      if (!hs_a[k]) cnt_hs++;
      if (!vs_a[k]) cnt_vs++;
      if (bn_a[k]) cnt_bn++;
      if (req_a[k] && load_a[k]) cnt_both++;
      if (first_load < 0 && load_a[k]) first_load = k;
      if (first_req < 0 && req_a[k]) first_req = k;
    end
    chk("load_fall", 32'(load_a[0]), 0);
    chk("load_start", 32'(first_load), 15);
    chk("load_len", 32'(cnt_load), 4);
    chk("first_req", 32'(first_req), 75);
    chk("req_count", 32'(cnt_req), 32);
    chk("req_load_excl", 32'(cnt_both), 0);
    chk("hs_low_count", 32'(cnt_hs), 27);
    chk("hs_edges", 32'({hs_a[11], hs_a[12], hs_a[14], hs_a[15]}), 32'b1001);
    chk("vs_low_count", 32'(cnt_vs), 30);
    chk("vs_edges", 32'({vs_a[16], vs_a[17], vs_a[46], vs_a[47]}), 32'b1001);
    chk("blank_count", 32'(cnt_bn), 32);
    chk("blank_edge", 32'({bn_a[76], bn_a[77]}), 32'b01);
    chk("rgb_red", 32'(rgb_a[77]), 32'hFF0000);
    chk("rgb_green", 32'(rgb_a[78]), 32'h00FF00);
    chk("rgb_blue", 32'(rgb_a[79]), 32'h0000FF);
    chk("rgb_blanked", 32'(rgb_a[85]), 0);
    chk("fcnt_before", 32'(fc_a[74]), 0);
    chk("fcnt_after", 32'(fc_a[75]), 1);
    chk("fcnt_frame", 32'(fc_a[135]), 1);

    // Drop EN mid-line at (h=3, v=2).
    RD_DATA = 16'h07E0;
    repeat (108) step();
    chk("stop_req_pre", 32'(RD_REQ), 1);
    chk("stop_fcnt_pre", 32'(FRAME_CNT), 2);
    EN = 1'b0;
    step();
    chk("stop_req", 32'(RD_REQ), 0);
    chk("stop_load", 32'(RD_LOAD), 1);
    step();
    chk("stop_blank", 32'(VGA_BLANK_N), 0);
    chk("stop_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
    chk("stop_syncs", 32'({VGA_HS, VGA_VS}), 3);
    repeat (5) step();
    chk("idle_fcnt_hold", 32'(FRAME_CNT), 2);

    // Restart must begin again in the vertical front porch.
    EN = 1'b1;
    first_load = -1; first_req = -1; load0 = -1;
    for (int k = 0; k < 200 && first_req < 0; k++) begin
      step();
      if (k == 0) load0 = int'(RD_LOAD);
      if (first_load < 0 && RD_LOAD) first_load = k;
      if (first_req < 0 && RD_REQ) first_req = k;
    end
    chk("restart_load0", 32'(load0), 0);
    chk("restart_load", 32'(first_load), 15);
    chk("restart_req", 32'(first_req), 75);

    // Reset mid-frame with EN still high.
    repeat (20) step();
    RESET = 1'b1;
    step();
    chk("mrst_fcnt", 32'(FRAME_CNT), 0);
    chk("mrst_ctrl", 32'({RD_LOAD, RD_REQ}), 32'b10);
    chk("mrst_video", 32'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 32'h6000000);
    step();
    chk("mrst_priority", 32'(RD_LOAD), 1);

    // Frame counter wraps from FFFF to 0.
    RESET = 1'b0;
    step();
    force dut.frame_cnt = 16'hFFFF;
    repeat (10) step();
    release dut.frame_cnt;
    repeat (65) step();
    chk("fcnt_wrap", 32'(FRAME_CNT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
